// File: rtl/sync_fifo_rd_ctrl.sv
// Read-side controller for sync_fifo: issues credit-limited reads, tolerates the
// FIFO's lagging empty flag and one-cycle read latency, and buffers words for a valid/ready consumer.
module sync_fifo_rd_ctrl #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_en,
    input  logic                  i_fifo_empty,
    input  logic                  i_fifo_alm_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rddata,
    output logic                  o_fifo_rden,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [15:0]           o_rd_count,
    output logic                  o_busy
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP2  = 2'd2,
        ST_GAP1  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  inflight_q;
    logic                  hold_q;
    logic [CNT_W-1:0]      rd_count_q, rd_count_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

    logic credit_c;
    logic issue_ok_c;
    logic rden_c;
    logic pop_c;
    logic cap_c;

    // Pops are ignored here, so the credit is conservative by one cycle.
    assign credit_c   = (occ_q + OCC_W'(inflight_q)) < OCC_W'(BUF_DEPTH);
    // No read in a reset cycle nor in the first cycle after it: the empty flag
    // may still reflect a read issued just before the reset.
    assign issue_ok_c = i_en && credit_c && !rstn && !hold_q;

    // Read-issue FSM: GAP2/GAP1 give the registered empty flag time to catch up.
    always_comb begin
        state_d = state_q;
        rden_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_ok_c && !i_fifo_empty) begin
                    rden_c  = 1'b1;
                    state_d = i_fifo_alm_empty ? ST_GAP2 : ST_BURST;
                end
            end
            ST_BURST: begin
                if (issue_ok_c && !i_fifo_alm_empty) begin
                    rden_c = 1'b1;
                end else begin
                    state_d = ST_GAP1;
                end
            end
            ST_GAP2: state_d = ST_GAP1;
            ST_GAP1: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Buffer bookkeeping: capture the word read last cycle, pop on handshake.
    always_comb begin
        pop_c      = o_valid && i_ready;
        cap_c      = inflight_q;
        head_d     = head_q + PTR_W'(pop_c);
        tail_d     = tail_q + PTR_W'(cap_c);
        rd_count_d = rd_count_q + CNT_W'(cap_c);
        occ_d      = occ_q;
        if (cap_c && !pop_c) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!cap_c && pop_c) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= rstn;
        if (rstn) begin
            state_q    <= ST_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= rden_c;
            rd_count_q <= rd_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (cap_c) begin
            buf_q[tail_q] <= i_fifo_rddata;
        end
    end

    assign o_fifo_rden = rden_c;
    assign o_valid     = (occ_q != '0);
    assign o_data      = buf_q[head_q];
    assign o_rd_count  = rd_count_q;
    assign o_busy      = inflight_q || o_valid || (state_q != ST_IDLE);

    a_occ_bound: assert property (@(posedge clk) disable iff (rstn)
        occ_q <= OCC_W'(BUF_DEPTH));

endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// Directed bench for sync_fifo_rd_ctrl with a behavioural sync_fifo model
// (registered empty, combinational almost-empty at LOW_TH, one-cycle read data).
module tb_sync_fifo_rd_ctrl;

    localparam int unsigned DW = 128;
    localparam int unsigned BD = 4;
    localparam int          LOW_TH = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          i_en = 1'b0;
    logic          ready = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_alm_empty;
    logic [DW-1:0] fifo_rddata = '0;
    logic          fifo_rden;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic [15:0]   o_rd_count;
    logic          o_busy;

    logic          wr_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] fq [$];
    int fifo_count = 0;
    int npop = 0;
    int bad_rd = 0;
    int wr_idx = 0;
    int del_idx = 0;
    int npop_rst = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync_fifo_rd_ctrl #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_en             (i_en),
        .i_fifo_empty     (fifo_empty),
        .i_fifo_alm_empty (fifo_alm_empty),
        .i_fifo_rddata    (fifo_rddata),
        .o_fifo_rden      (fifo_rden),
        .o_valid          (o_valid),
        .i_ready          (ready),
        .o_data           (o_data),
        .o_rd_count       (o_rd_count),
        .o_busy           (o_busy)
    );

    // FIFO model; empty is registered from the pre-edge count.
    always @(posedge clk) begin : fifo_model
        int sz;
        sz = fq.size();
        fifo_empty <= (sz == 0);
        if (fifo_rden === 1'b1) begin
            if (sz == 0) bad_rd++;
            else begin
                fifo_rddata <= fq.pop_front();
                npop++;
            end
        end
        if (wr_req) fq.push_back(wr_data);
        fifo_count <= fq.size();
    end
    assign fifo_alm_empty = (fifo_count <= LOW_TH);

    function automatic logic [DW-1:0] wd(input int k);
        logic [31:0] w;
        w = 32'(k);
        return {w, ~w, w ^ 32'hA5A5_5A5A, w + 32'hC0DE_0000};
    endfunction

    task automatic preload(input int n);
        @(negedge clk);
        i_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_req  = 1'b1;
            wr_data = wd(wr_idx);
            wr_idx++;
            @(negedge clk);
        end
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b1; i_en = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        tests++; if (fifo_rden !== 1'b0) begin fails++; $display("FAIL reset_rden got %b want 0", fifo_rden); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
        tests++; if (o_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", o_data); end
        tests++; if (o_rd_count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", o_rd_count); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", o_busy); end
    endtask

    task automatic test_burst_drain();
        int exp_off [8] = '{0, 1, 2, 3, 4, 5, 8, 11};
        int rd_off [$];
        logic busy_h [40];
        int first_rd, first_val, last_pop, ndel, base;
        preload(8);
        base = npop - npop_rst;
        first_rd = -1; first_val = -1; last_pop = -1; ndel = 0;
        i_en = 1'b1; ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            busy_h[c] = o_busy;
            if (fifo_rden) begin
                if (first_rd < 0) first_rd = c;
                rd_off.push_back(c - first_rd);
            end
            if (o_valid && ready) begin
                if (first_val < 0) first_val = c;
                tests++; if (o_data !== wd(del_idx)) begin fails++; $display("FAIL drain_data got %h want %h", o_data, wd(del_idx)); end
                del_idx++; ndel++; last_pop = c;
            end
        end
        tests++; if (rd_off.size() != 8) begin fails++; $display("FAIL drain_nreads got %0d want 8", rd_off.size()); end
        for (int i = 0; i < 8 && i < rd_off.size(); i++) begin
            tests++; if (rd_off[i] != exp_off[i]) begin fails++; $display("FAIL drain_rd_cycle[%0d] got %0d want %0d", i, rd_off[i], exp_off[i]); end
        end
        tests++; if (first_val != first_rd + 2) begin fails++; $display("FAIL drain_latency got %0d want %0d", first_val, first_rd + 2); end
        tests++; if (ndel != 8) begin fails++; $display("FAIL drain_ndel got %0d want 8", ndel); end
        tests++; if (o_rd_count !== 16'(base + 8)) begin fails++; $display("FAIL drain_count got %0d want %0d", o_rd_count, base + 8); end
        tests++; if (bad_rd != 0) begin fails++; $display("FAIL drain_empty_read got %0d want 0", bad_rd); end
        if (last_pop >= 0 && last_pop + 2 < 40) begin
            tests++; if (busy_h[last_pop] !== 1'b1) begin fails++; $display("FAIL drain_busy_at_pop got %b want 1", busy_h[last_pop]); end
            tests++; if (busy_h[last_pop + 2] !== 1'b0) begin fails++; $display("FAIL drain_busy_after got %b want 0", busy_h[last_pop + 2]); end
        end else begin
            tests++; fails++; $display("FAIL drain_last_pop got %0d want <38", last_pop);
        end
    endtask

    task automatic test_backpressure();
        int nrd, ndel;
        logic seen;
        preload(10);
        nrd = 0; ndel = 0; seen = 1'b0;
        i_en = 1'b1; ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (fifo_rden) nrd++;
            if (o_valid) seen = 1'b1;
            if (seen) begin
                tests++;
                if (o_valid !== 1'b1 || o_data !== wd(del_idx)) begin
                    fails++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=%h", o_valid, o_data, wd(del_idx));
                end
            end
        end
        tests++; if (nrd != 4) begin fails++; $display("FAIL bp_nreads got %0d want 4", nrd); end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ready = 1'b1;
            #1;
            if (o_valid && ready) begin
                tests++; if (o_data !== wd(del_idx)) begin fails++; $display("FAIL bp_data got %h want %h", o_data, wd(del_idx)); end
                del_idx++; ndel++;
            end
        end
        tests++; if (ndel != 10) begin fails++; $display("FAIL bp_ndel got %0d want 10", ndel); end
    endtask

    task automatic test_trickle();
        int rdq [$];
        int last_rd, ndel;
        last_rd = -100; ndel = 0;
        i_en = 1'b1; ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            wr_req = (c < 40) && (c % 5 == 0);
            if (wr_req) begin wr_data = wd(wr_idx); wr_idx++; end
            #1;
            if (fifo_rden) begin
                tests++; if (c - last_rd < 3) begin fails++; $display("FAIL trickle_spacing got %0d want >=3", c - last_rd); end
                last_rd = c;
                rdq.push_back(c);
            end
            if (o_valid && ready) begin
                tests++; if (o_data !== wd(del_idx)) begin fails++; $display("FAIL trickle_data got %h want %h", o_data, wd(del_idx)); end
                tests++;
                if (rdq.size() == 0 || c != rdq[0] + 2) begin
                    fails++; $display("FAIL trickle_latency got cycle %0d want read+2", c);
                end
                if (rdq.size() != 0) void'(rdq.pop_front());
                del_idx++; ndel++;
            end
        end
        wr_req = 1'b0;
        tests++; if (ndel != 8) begin fails++; $display("FAIL trickle_ndel got %0d want 8", ndel); end
        tests++; if (bad_rd != 0) begin fails++; $display("FAIL trickle_empty_read got %0d want 0", bad_rd); end
    endtask

    task automatic test_enable_toggle();
        int first, ndel, base;
        preload(10);
        base = npop - npop_rst;
        first = -1; ndel = 0;
        i_en = 1'b1; ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c != 0) @(negedge clk);
            if (first >= 0 && c == first + 3) i_en = 1'b0;
            else if (first >= 0 && c == first + 4) i_en = 1'b1;
            #1;
            if (first < 0 && fifo_rden) first = c;
            if (first >= 0 && c == first + 3) begin
                tests++; if (fifo_rden !== 1'b0) begin fails++; $display("FAIL en_drop_rden got %b want 0", fifo_rden); end
            end
            if (first >= 0 && c == first + 4) begin
                tests++; if (fifo_rden !== 1'b0) begin fails++; $display("FAIL en_gap1_rden got %b want 0", fifo_rden); end
                tests++; if (o_rd_count !== 16'(base + 3)) begin fails++; $display("FAIL en_inflight_count got %0d want %0d", o_rd_count, base + 3); end
            end
            if (first >= 0 && c == first + 5) begin
                tests++; if (fifo_rden !== 1'b1) begin fails++; $display("FAIL en_resume_rden got %b want 1", fifo_rden); end
            end
            if (o_valid && ready) begin
                tests++; if (o_data !== wd(del_idx)) begin fails++; $display("FAIL en_data got %h want %h", o_data, wd(del_idx)); end
                del_idx++; ndel++;
            end
        end
        tests++; if (ndel != 10) begin fails++; $display("FAIL en_ndel got %0d want 10", ndel); end
    endtask

    task automatic test_reset_mid_burst();
        int first, ndel;
        logic done;
        preload(12);
        first = -1; ndel = 0; done = 1'b0;
        i_en = 1'b1; ready = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c != 0) @(negedge clk);
            if (first >= 0 && c == first + 4) rstn = 1'b1;
            else if (first >= 0 && c == first + 5) rstn = 1'b0;
            #1;
            if (first < 0 && fifo_rden) first = c;
            if (first >= 0 && c == first + 4) begin
                tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid got %b want 1", o_valid); end
            end
            if (first >= 0 && c == first + 5) begin
                tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", o_valid); end
                tests++; if (o_rd_count !== 16'd0) begin fails++; $display("FAIL rstmid_count got %0d want 0", o_rd_count); end
                tests++; if (fifo_rden !== 1'b0) begin fails++; $display("FAIL rstmid_rden got %b want 0", fifo_rden); end
                npop_rst = npop;
                del_idx  = npop;
                done = 1'b1;
            end
        end
        tests++; if (!done) begin fails++; $display("FAIL rstmid_timeout got %0d want 1", done); end
        rstn = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ready = 1'b1;
            #1;
            if (o_valid && ready) begin
                tests++; if (o_data !== wd(del_idx)) begin fails++; $display("FAIL rstmid_data got %h want %h", o_data, wd(del_idx)); end
                del_idx++; ndel++;
            end
        end
        tests++; if (ndel != 8) begin fails++; $display("FAIL rstmid_ndel got %0d want 8", ndel); end
        tests++; if (o_rd_count !== 16'd8) begin fails++; $display("FAIL rstmid_count_after got %0d want 8", o_rd_count); end
        tests++; if (bad_rd != 0) begin fails++; $display("FAIL rstmid_empty_read got %0d want 0", bad_rd); end
    endtask

    task automatic test_counter_wrap();
        int ndel, nwr;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        npop_rst = npop;
        del_idx  = npop;
        ndel = 0; nwr = 0;
        i_en = 1'b1; ready = 1'b1;
        for (int c = 0; c < 70000 && ndel < 65537; c++) begin
            @(negedge clk);
            wr_req = (nwr < 65537);
            if (wr_req) begin wr_data = wd(wr_idx); wr_idx++; nwr++; end
            #1;
            if (o_valid && ready) begin
                tests++; if (o_data !== wd(del_idx)) begin fails++; $display("FAIL wrap_data[%0d] got %h want %h", ndel, o_data, wd(del_idx)); end
                del_idx++; ndel++;
            end
        end
        wr_req = 1'b0;
        tests++; if (ndel != 65537) begin fails++; $display("FAIL wrap_ndel got %0d want 65537", ndel); end
        tests++; if (o_rd_count !== 16'd1) begin fails++; $display("FAIL wrap_count got %0d want 1", o_rd_count); end
        tests++; if (bad_rd != 0) begin fails++; $display("FAIL wrap_empty_read got %0d want 0", bad_rd); end
    endtask

    initial begin
        test_reset();
        test_burst_drain();
        test_backpressure();
        test_trickle();
        test_enable_toggle();
        test_reset_mid_burst();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
